// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the HI/LO multiply/divide unit: command encoding,
// in-flight stall, MFHI/MFLO return and a latency tracker cross-checked against md_busy.
module md_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        flush,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [2:0]  md_op,
  output logic [1:0]  md_mthilo,
  output logic [31:0] md_srca,
  output logic [31:0] md_srcb,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic        sync_err
);

  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [2:0] CMD_IDLE = 3'b111;
  localparam logic [1:0] MT_LO    = 2'b00;
  localparam logic [1:0] MT_HI    = 2'b01;
  localparam logic [1:0] MT_IDLE  = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  mthilo;
    logic [31:0] srca;
    logic [31:0] srcb;
  } md_cmd_t;

  state_t     state;
  logic [3:0] cnt;
  logic       md_class, issue, is_mul, is_div, waiting;
  md_cmd_t    cmd;

  assign waiting  = (state != IDLE);
  assign md_class = e_valid && !flush && (e_op >= OP_MULTU) && (e_op <= OP_MTLO);
  assign stall    = md_class && (waiting || md_busy);
  assign issue    = md_class && !stall;
  assign is_mul   = (e_op == OP_MULTU) || (e_op == OP_MULT);
  assign is_div   = (e_op == OP_DIVU) || (e_op == OP_DIV);

  // Operands follow any MD-class instruction so the unit sees them on the issue edge.
  always_comb begin
    cmd        = '{op: CMD_IDLE, mthilo: MT_IDLE, srca: '0, srcb: '0};
    mf_data    = '0;
    if (md_class) begin
      cmd.srca = e_rs;
      cmd.srcb = e_rt;
    end
    if (issue) begin
      unique case (e_op)
        OP_MULTU: cmd.op     = 3'b000;
        OP_MULT:  cmd.op     = 3'b001;
        OP_DIVU:  cmd.op     = 3'b010;
        OP_DIV:   cmd.op     = 3'b011;
        OP_MTHI:  cmd.mthilo = MT_HI;
        OP_MTLO:  cmd.mthilo = MT_LO;
        OP_MFHI:  mf_data    = md_hi;
        OP_MFLO:  mf_data    = md_lo;
        default:  ;
      endcase
    end
  end

  assign md_op     = cmd.op;
  assign md_mthilo = cmd.mthilo;
  assign md_srca   = cmd.srca;
  assign md_srcb   = cmd.srcb;

  // Tracker mirrors the unit's busy window; any disagreement latches sync_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync_err | (waiting != md_busy);
      case (state)
        IDLE: begin
          if (issue && is_mul) begin
            state <= MUL_WAIT;
            cnt   <= 4'(MUL_CYCLES);
          end else if (issue && is_div) begin
            state <= DIV_WAIT;
            cnt   <= 4'(DIV_CYCLES);
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: behavioural MD unit stub plus a cycle-indexed reference
// of the issue rules; directed scenarios followed by random traffic.
module tb_md_issue_ctrl;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = '0;
  logic [31:0] e_rs = '0, e_rt = '0;
  logic        flush = 1'b0;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;
  logic [2:0]  md_op;
  logic [1:0]  md_mthilo;
  logic [31:0] md_srca, md_srcb, mf_data;
  logic        stall, sync_err;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
    .flush(flush), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo), .md_op(md_op),
    .md_mthilo(md_mthilo), .md_srca(md_srca), .md_srcb(md_srcb), .stall(stall),
    .mf_data(mf_data), .sync_err(sync_err)
  );

  // k: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV; returns {hi, lo}
  function automatic logic [63:0] md_calc(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (k)
      2'd0:    r = {32'b0, a} * {32'b0, b};
      2'd1:    r = 64'(sa * sb);
      2'd2:    r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
    endcase
    return r;
  endfunction

  // MD unit stub, driven by the DUT's command outputs
  logic [3:0]  bcnt = '0;
  logic [31:0] hi = '0, lo = '0;
  logic        force_busy = 1'b0;
  assign md_busy = (bcnt != 0) || force_busy;
  assign md_hi = hi;
  assign md_lo = lo;

  always @(posedge clk) begin
    if (reset) begin
      bcnt <= '0; hi <= '0; lo <= '0;
    end else begin
      if (bcnt != 0) bcnt <= bcnt - 4'd1;
      if (md_op != 3'b111) begin
        {hi, lo} <= md_calc(md_op[1:0], md_srca, md_srcb);
        bcnt <= md_op[1] ? 4'(DIVN) : 4'(MULN);
      end
      if (md_mthilo == 2'b00) lo <= md_srca;
      else if (md_mthilo == 2'b01) hi <= md_srca;
    end
  end

  // reference state
  int cyc = 0, wait_end = -1;
  logic [31:0] rhi = '0, rlo = '0;
  logic rerr = 1'b0;
  int total = 0, bad = 0;
  logic [2:0] o_op;
  logic [1:0] o_mt;
  logic [31:0] o_mf;
  logic o_st, o_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    logic cls, waiting, est, iss;
    logic [2:0] eop;
    logic [1:0] emt;
    logic [31:0] emf;
    e_valid = v; e_op = op; e_rs = rs; e_rt = rt; flush = fl;
    #4;
    cls     = v && !fl && op >= 1 && op <= 8;
    waiting = cyc <= wait_end;
    est     = cls && (waiting || md_busy);
    iss     = cls && !est;
    eop = 3'b111;
    if (iss && op >= 1 && op <= 4) eop = 3'(op - 4'd1);
    emt = 2'b11;
    if (iss && op == 8) emt = 2'b00;
    if (iss && op == 7) emt = 2'b01;
    emf = '0;
    if (iss && op == 5) emf = rhi;
    if (iss && op == 6) emf = rlo;
    chk("stall", 32'(stall), 32'(est));
    chk("md_op", 32'(md_op), 32'(eop));
    chk("md_mthilo", 32'(md_mthilo), 32'(emt));
    chk("md_srca", md_srca, cls ? rs : 32'h0);
    chk("md_srcb", md_srcb, cls ? rt : 32'h0);
    chk("mf_data", mf_data, emf);
    chk("sync_err", 32'(sync_err), 32'(rerr));
    o_op = md_op; o_mt = md_mthilo; o_mf = mf_data; o_st = stall; o_err = sync_err;
    rerr = rerr | (waiting != md_busy);
    if (iss && op >= 1 && op <= 4) begin
      {rhi, rlo} = md_calc(2'(op - 4'd1), rs, rt);
      wait_end = cyc + ((op <= 2) ? MULN : DIVN);
    end
    if (iss && op == 7) rhi = rs;
    if (iss && op == 8) rlo = rs;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; e_valid = 1'b0; flush = 1'b0;
    #4;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_md_op", 32'(md_op), 32'h7);
    chk("rst_mthilo", 32'(md_mthilo), 32'h3);
    chk("rst_mf", mf_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc++; wait_end = -1; rerr = 1'b0; rhi = '0; rlo = '0;
    chk("rst_sync_err", 32'(sync_err), 32'h0);
  endtask

  // present an MF op until it issues; n = stalled cycles (bounded)
  task automatic hold(input logic [3:0] op, output int n);
    int g;
    n = 0; g = 0;
    do begin
      drive(1'b1, op, 32'h0, 32'h0, 1'b0);
      if (o_st) n++;
      g++;
    end while (o_st && g < 40);
  endtask

  int n;

  initial begin
    @(posedge clk); #1;
    do_reset();

    // MULT signed -1 * 2
    drive(1, 4'd2, 32'hFFFFFFFF, 32'd2, 0);
    chk("mult_op", 32'(o_op), 32'h1);
    hold(4'd5, n);
    chk("mult_stalls", n, 32'd5);
    chk("mult_hi", o_mf, 32'hFFFFFFFF);
    drive(1, 4'd6, 0, 0, 0);
    chk("mult_lo", o_mf, 32'hFFFFFFFE);

    // MULTU same operands
    drive(1, 4'd1, 32'hFFFFFFFF, 32'd2, 0);
    chk("multu_op", 32'(o_op), 32'h0);
    hold(4'd5, n);
    chk("multu_stalls", n, 32'd5);
    chk("multu_hi", o_mf, 32'h1);

    // DIV 7 / -2
    drive(1, 4'd4, 32'd7, 32'hFFFFFFFE, 0);
    chk("div_op", 32'(o_op), 32'h3);
    hold(4'd6, n);
    chk("div_stalls", n, 32'd10);
    chk("div_lo", o_mf, 32'hFFFFFFFD);
    drive(1, 4'd5, 0, 0, 0);
    chk("div_hi", o_mf, 32'h1);

    // MTHI then MFHI back to back
    drive(1, 4'd7, 32'h12345678, 0, 0);
    chk("mthi_mt", 32'(o_mt), 32'h1);
    chk("mthi_stall", 32'(o_st), 32'h0);
    drive(1, 4'd5, 0, 0, 0);
    chk("mfhi_stall", 32'(o_st), 32'h0);
    chk("mfhi_data", o_mf, 32'h12345678);

    // flushed MULT never issues
    drive(1, 4'd2, 32'd3, 32'd4, 1);
    chk("flush_op", 32'(o_op), 32'h7);
    drive(1, 4'd6, 0, 0, 0);
    chk("flush_nostall", 32'(o_st), 32'h0);

    // non-MD op passes while waiting
    drive(1, 4'd1, 32'd9, 32'd9, 0);
    drive(1, 4'd9, 0, 0, 0);
    chk("nonmd_nostall", 32'(o_st), 32'h0);
    drive(1, 4'd0, 0, 0, 0);
    chk("none_nostall", 32'(o_st), 32'h0);
    hold(4'd6, n);
    chk("multu9_lo", o_mf, 32'd81);

    // reset on the 4th divide wait cycle
    drive(1, 4'd3, 32'd100, 32'd7, 0);
    for (int i = 0; i < 3; i++) drive(1, 4'd6, 0, 0, 0);
    chk("pre_rst_stall", 32'(o_st), 32'h1);
    do_reset();
    drive(1, 4'd6, 0, 0, 0);
    chk("post_rst_stall", 32'(o_st), 32'h0);
    chk("post_rst_mf", o_mf, 32'h0);

    // busy while idle -> sticky sync_err
    force_busy = 1'b1;
    drive(1, 4'd0, 0, 0, 0);
    drive(1, 4'd0, 0, 0, 0);
    chk("sync_err_set", 32'(o_err), 32'h1);
    force_busy = 1'b0;
    for (int i = 0; i < 3; i++) drive(0, 4'd0, 0, 0, 0);
    chk("sync_err_sticky", 32'(o_err), 32'h1);
    do_reset();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] rt;
      rt = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      drive($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), $urandom, rt,
            $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side issue controller for the multiply/divide unit. It sits in the E stage between the decoded instruction and the HI/LO multiply/divide unit. It translates MD-class instructions into the unit's command encoding, stalls the pipeline while an operation is in flight, and returns HI/LO for MFHI/MFLO. A local latency tracker mirrors the unit's busy counter and flags any disagreement.

## Interface
- MUL_CYCLES, 5, busy cycles after a MULT/MULTU issue; must equal the unit's multiply latency
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU issue; must equal the unit's divide latency
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- e_valid  in  1  E-stage instruction valid
- e_op  in  4  0 NONE, 1 MULTU, 2 MULT, 3 DIVU, 4 DIV, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
- e_rs  in  32  rs operand, forwarded value
- e_rt  in  32  rt operand, forwarded value
- flush  in  1  kills the E-stage instruction this cycle
- md_busy  in  1  busy from the MD unit
- md_hi, md_lo  in  32 each  HI/LO from the MD unit
- md_op  out  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 111 idle
- md_mthilo  out  2  00 write LO, 01 write HI, 11 idle
- md_srca, md_srcb  out  32 each  operands to the MD unit
- stall  out  1  freeze IF/D/E and bubble M
- mf_data  out  32  HI or LO for MFHI/MFLO, else 0
- sync_err  out  1  sticky tracker/busy mismatch

## Operation
- md_class = e_valid && !flush && e_op in 1..8.
- stall = md_class && (state != IDLE || md_busy).
- issue = md_class && !stall.
- md_op is the encoding of e_op only when issue && e_op in 1..4; otherwise 111.
- md_mthilo is 00 for issue of MTLO and 01 for issue of MTHI; otherwise 11.
- md_op and md_mthilo are never non-idle together.
- md_srca = e_rs and md_srcb = e_rt whenever md_class; otherwise 0.
- mf_data = md_hi for issue of MFHI, md_lo for issue of MFLO; otherwise 0.
- FSM states: IDLE, MUL_WAIT, DIV_WAIT. State and the 4-bit counter cnt are registered.
  - IDLE: issue of MULT/MULTU moves to MUL_WAIT with cnt=MUL_CYCLES. Issue of DIV/DIVU moves to DIV_WAIT with cnt=DIV_CYCLES. Any other input stays in IDLE.
  - MUL_WAIT / DIV_WAIT: cnt decrements each cycle. When cnt==1 at the clock edge, the FSM moves to IDLE with cnt=0. Inputs are ignored in these states; issue is impossible because md_class stalls.
- sync_err sets in any cycle where (state != IDLE) != md_busy. It is cleared only by reset.
- Non-MD instructions (e_op 0 or 9-15) never stall, even while the FSM is waiting.
- flush overrides everything: no issue, no stall, no state change.

## Timing
- Reset: state IDLE, cnt 0, sync_err 0. All combinational outputs take their idle values: md_op 111, md_mthilo 11, stall 0, mf_data 0.
- The command is combinational in the issue cycle and is sampled by the MD unit on the same clk edge.
- A multiply issued at edge T keeps the FSM waiting for cycles T+1..T+MUL_CYCLES. An MD instruction presented in those cycles stalls. The first non-stalled cycle is T+MUL_CYCLES+1. Divide is the same with DIV_CYCLES.
- MTHI/MTLO write at the issue edge. An MFHI/MFLO in the very next cycle sees the new value with no stall.
- Reset mid-operation: FSM returns to IDLE at the reset edge, and the MD unit resets on the same shared reset. No stall persists.
- Back-to-back MD ops: the second one is held by stall until the FSM returns to IDLE, then issues in that cycle.

## Test plan
- MULT: e_rs=0xFFFFFFFF, e_rt=2, followed by MFHI -> md_op=001 in the issue cycle. stall=1 for exactly 5 cycles, then mf_data=0xFFFFFFFF; a following MFLO gives 0xFFFFFFFE.
- MULTU with the same operands, then MFHI -> mf_data=0x00000001 after 5 stall cycles.
- DIV: e_rs=7, e_rt=0xFFFFFFFE, then MFLO -> md_op=011. stall=1 for 10 cycles, then mf_data=0xFFFFFFFD; a following MFHI gives 0x00000001.
- MTHI e_rs=0x12345678 in IDLE, then MFHI the next cycle -> md_mthilo=01, stall stays 0, mf_data=0x12345678.
- MULT with flush=1 -> md_op=111, state remains IDLE. A following MFLO does not stall.
- DIV issued, reset asserted on the 4th wait cycle, then MFLO -> stall=0 and mf_data=0. Separately, force md_busy=1 while IDLE -> sync_err=1 and it stays 1 until reset.
